// File: rtl/stream_mux_nto1_if.sv
// stream_mux_nto1_if: handshake and data bundle for the N-to-1 stream mux.
// The "slave" modport is the mux itself; "master" is the surrounding logic
// that drives the input channels, the select and the downstream ready.
interface stream_mux_nto1_if #(
    parameter int WIDTH = 64,
    parameter int N     = 4
);
    localparam int SEL_W = $clog2(N);

    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [SEL_W-1:0]   sel;
    logic [WIDTH-1:0]   out_data;
    logic [SEL_W-1:0]   out_src;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output in_data, in_valid, sel, out_ready,
        input  in_ready, out_data, out_src, out_valid
    );

    modport slave (
        input  in_data, in_valid, sel, out_ready,
        output in_ready, out_data, out_src, out_valid
    );
endinterface

// File: rtl/stream_mux_nto1.sv
// stream_mux_nto1: N-to-1 valid/ready multiplexer with one registered output
// stage. In the default build the channel is chosen by sel. Defining the
// macro MUX_RR_ARB_EN replaces sel with a round-robin arbiter over the valid
// channels.
module stream_mux_nto1 #(
    parameter int WIDTH = 64,
    parameter int N     = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    stream_mux_nto1_if.slave    bus
);
    localparam int SEL_W = $clog2(N);
    // N widened by one bit so it can be compared against an index without
    // truncation when N is a power of two.
    localparam logic [SEL_W:0] N_EXT = (SEL_W+1)'(N);

    logic             load;
    logic [SEL_W-1:0] g;
    logic             grant_ok;
    logic             xfer;
    logic [WIDTH-1:0] g_data;

    // Stage can take a new word when it is empty or is being drained now.
    assign load = !bus.out_valid || bus.out_ready;

`ifdef MUX_RR_ARB_EN
    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W:0]   rr_idx;
    logic             unused_sel;

    assign unused_sel = ^bus.sel;

    // Round-robin grant: first valid channel at or after rr_ptr, with wrap.
    // Scanning from the far end lets the nearest candidate win last.
    always_comb begin
        g        = '0;
        grant_ok = 1'b0;
        rr_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            rr_idx = {1'b0, rr_ptr} + (SEL_W+1)'(k);
            if (rr_idx >= N_EXT) rr_idx = rr_idx - N_EXT;
            if (bus.in_valid[rr_idx[SEL_W-1:0]]) begin
                g        = rr_idx[SEL_W-1:0];
                grant_ok = 1'b1;
            end
        end
    end

    // Pointer moves past the channel just served; holds when nothing moves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (xfer) begin
            rr_ptr <= (g == SEL_W'(N - 1)) ? '0 : g + 1'b1;
        end
    end
`else
    // Select-driven grant; an out-of-range sel grants nothing.
    always_comb begin
        g        = bus.sel;
        grant_ok = ({1'b0, bus.sel} < N_EXT);
    end
`endif

    assign xfer = load && grant_ok && bus.in_valid[g];

    // Ready goes only to the granted channel and never looks at in_valid.
    // NOTE: gated by rst_n so in_ready drops the moment reset asserts, not at
    // the next clock edge.
    always_comb begin
        bus.in_ready = '0;
        for (int i = 0; i < N; i++) begin
            if (rst_n && load && grant_ok && (g == SEL_W'(i))) bus.in_ready[i] = 1'b1;
        end
    end

    // Data mux: pick the granted channel's word.
    always_comb begin
        g_data = '0;
        for (int i = 0; i < N; i++) begin
            if (g == SEL_W'(i)) g_data = bus.in_data[i*WIDTH +: WIDTH];
        end
    end

    // Output register: fill on transfer, drain on load without transfer,
    // hold everything while stalled.
    // NOTE: state registers use non-blocking assignments so every register
    // in this block sees pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_src   <= '0;
        end else if (load) begin
            if (xfer) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= g_data;
                bus.out_src   <= g;
            end else begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_stream_mux_nto1.sv
// tb_stream_mux_nto1: directed bench for stream_mux_nto1 with N=4, WIDTH=64.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_stream_mux_nto1;
    localparam int WIDTH = 64;
    localparam int N     = 4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    stream_mux_nto1_if #(.WIDTH(WIDTH), .N(N)) bus ();

    stream_mux_nto1 #(.WIDTH(WIDTH), .N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [WIDTH-1:0] val);
        bus.in_data[ch*WIDTH +: WIDTH] = val;
    endtask

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        rst_n         = 1'b0;
        bus.in_data   = '0;
        bus.in_valid  = '0;
        bus.sel       = '0;
        bus.out_ready = 1'b0;
        #1;
        check("reset_out_valid", 64'(bus.out_valid), 64'h0);
        check("reset_in_ready",  64'(bus.in_ready),  64'h0);
        tick();
        tick();
        rst_n = 1'b1;

        // Pass-through on channel 2.
        bus.sel       = 2'd2;
        bus.in_valid  = 4'b0100;
        set_ch(2, 64'hDEAD_BEEF);
        bus.out_ready = 1'b1;
        #1;
        check("pt_in_ready", 64'(bus.in_ready), 64'h4);
        tick();
        check("pt_out_valid", 64'(bus.out_valid), 64'h1);
        check("pt_out_data",  bus.out_data,       64'hDEAD_BEEF);
        check("pt_out_src",   64'(bus.out_src),   64'h2);

        // Backpressure: next word pending on ch2 while downstream stalls.
        set_ch(2, 64'h1234);
        bus.out_ready = 1'b0;
        #1;
        check("bp_in_ready_0", 64'(bus.in_ready), 64'h0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("bp_in_ready", 64'(bus.in_ready),  64'h0);
            check("bp_out_data", bus.out_data,       64'hDEAD_BEEF);
            check("bp_out_valid", 64'(bus.out_valid), 64'h1);
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_release_ready", 64'(bus.in_ready), 64'h4);
        tick();
        check("bp_reload_valid", 64'(bus.out_valid), 64'h1);
        check("bp_reload_data",  bus.out_data,       64'h1234);

        // Drain: nothing valid on selected channel 1.
        bus.sel      = 2'd1;
        bus.in_valid = 4'b0000;
        tick();
        check("drain_out_valid", 64'(bus.out_valid), 64'h0);
        check("drain_out_data",  bus.out_data,       64'h1234);
        check("drain_out_src",   64'(bus.out_src),   64'h2);

`ifndef MUX_RR_ARB_EN
        // Unselected valid channels are ignored; selected ch3 is idle.
        bus.sel      = 2'd3;
        bus.in_valid = 4'b0111;
        #1;
        check("unsel_in_ready", 64'(bus.in_ready), 64'h8);
        tick();
        check("unsel_out_valid", 64'(bus.out_valid), 64'h0);

        // Streaming 1..8 on channel 0.
        bus.sel      = 2'd0;
        bus.in_valid = 4'b0001;
        for (int k = 1; k <= 8; k++) begin
            set_ch(0, 64'(k));
            tick();
            check("stream_valid", 64'(bus.out_valid), 64'h1);
            check("stream_data",  bus.out_data,       64'(k));
            check("stream_src",   64'(bus.out_src),   64'h0);
        end
        bus.in_valid = 4'b0000;
        tick();
        check("stream_end_valid", 64'(bus.out_valid), 64'h0);
`else
        begin
            logic [1:0] exp_a [8];
            logic [1:0] exp_b [4];
            exp_a = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
            exp_b = '{2'd0, 2'd2, 2'd3, 2'd0};
            for (int i = 0; i < N; i++) set_ch(i, 64'hA0 + 64'(i));
            bus.sel      = 2'd3;
            bus.in_valid = 4'b1111;
            for (int k = 0; k < 8; k++) begin
                tick();
                check("rr_all_src",  64'(bus.out_src),  64'(exp_a[k]));
                check("rr_all_data", bus.out_data,      64'hA0 + 64'(exp_a[k]));
            end
            bus.in_valid = 4'b1101;
            for (int k = 0; k < 4; k++) begin
                tick();
                check("rr_drop1_src", 64'(bus.out_src), 64'(exp_b[k]));
            end
            bus.in_valid = 4'b0000;
            tick();
            check("rr_idle_valid", 64'(bus.out_valid), 64'h0);
        end
`endif

        // Asynchronous reset mid-stream, away from any clock edge.
        bus.sel      = 2'd0;
        bus.in_valid = 4'b0001;
        set_ch(0, 64'h55);
        tick();
        check("prerst_valid", 64'(bus.out_valid), 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid",    64'(bus.out_valid), 64'h0);
        check("async_rst_data",     bus.out_data,       64'h0);
        check("async_rst_src",      64'(bus.out_src),   64'h0);
        check("async_rst_in_ready", 64'(bus.in_ready),  64'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_data", bus.out_data, 64'h55);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
